sort_three_floats_seq: RTL and testbench
========================================

# sort_three_floats_seq

Multi-cycle sorter for three FLEN-bit floating-point numbers that owns a single `f_less_or_equal` comparator and time-shares it across three compare-and-swap steps. It is the area-reduced alternative to the fully combinational three-comparator sorter. It sits between a valid/ready producer and consumer and runs one sort job at a time. Comparator errors (NaN operands) abort the job early and are flagged on the output.

## Interface
- `FLEN`: default from `config-shared.vh` (64). Width of each floating-point operand.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `up_valid`  in  1  input triple valid.
- `up_ready`  out  1  block can accept a triple.
- `unsorted`  in  [0:2][FLEN-1:0]  input triple, sampled on the accept edge only.
- `down_valid`  out  1  result valid.
- `down_ready`  in  1  consumer accepts result.
- `sorted`  out  [0:2][FLEN-1:0]  result; `sorted[0]` ≤ `sorted[1]` ≤ `sorted[2]` when `err`=0.
- `err`  out  1  the job hit a comparator error; qualified by `down_valid`.
- Exactly one `f_less_or_equal` instance. No other comparison logic.

## Operation
- Internal state: data registers `r[0:2]` (FLEN each), sticky `err_r`, and an FSM with states IDLE, C01, C12, C01B, DONE.
- IDLE: `up_ready`=1. On `up_valid`&&`up_ready`, load `r` ← `unsorted`, clear `err_r`, go to C01.
- The comparator is driven `a`=`r[0]`, `b`=`r[1]` in C01, C01B, IDLE and DONE, and `a`=`r[1]`, `b`=`r[2]` in C12.
- Compare step (C01, C12, C01B), one cycle each:
  - Comparator err=1: no swap, set `err_r`, go to DONE.
  - Else if res=0 (a > b): swap the two compared registers.
  - Else (a ≤ b, ties included): hold. Ties never swap, so the sort is stable.
- Transitions on no error: C01→C12→C01B→DONE.
- DONE: `down_valid`=1, `up_ready`=0. On `down_ready`, go to IDLE. No new job is accepted in the same cycle.
- `sorted` = `r` and `err` = `err_r` continuously. Both are meaningful only while `down_valid`=1 and are held stable while `down_valid`=1 and `down_ready`=0.
- On an aborted job, `sorted` holds the partially sorted registers at abort time. Its contents are unspecified to the consumer.
- `up_ready` and `down_valid` are decoded from state only. Neither depends combinationally on `up_valid` or `down_ready`.

## Timing
- Reset values: state IDLE, `r`=0, `err_r`=0. After reset: `up_ready`=1, `down_valid`=0, `sorted`=0, `err`=0.
- Latency on no error: accept edge at cycle N, then `down_valid`=1 from cycle N+3.
- Latency on error in step k (k=1..3): `down_valid`=1 from cycle N+k.
- Throughput: at most one job per 5 cycles with `down_ready` held high (accept, 3 compares, drain). The next `up_ready` comes one cycle after the drain edge.
- `up_valid` while not in IDLE is ignored, and `unsorted` is not sampled.
- `rst` asserted in any state wins over every other event. The next cycle is IDLE with all registers cleared, and the in-flight job is dropped without producing `down_valid`.
- `down_ready` outside DONE has no effect.

## Test plan
- Basic sort: `unsorted`={0x4008000000000000 (3.0), 0x3FF0000000000000 (1.0), 0x4000000000000000 (2.0)}, `down_ready`=1. Required: `down_valid` exactly 3 cycles after accept, `sorted`={1.0, 2.0, 3.0}, `err`=0, `up_ready` back one cycle after drain.
- Worst case and ties:
  - {3.0, 2.0, 1.0} → {1.0, 2.0, 3.0}.
  - {2.0, 0xBFF0000000000000 (−1.0), 2.0} → {−1.0, 2.0, 2.0}.
  - Already sorted {−1.0, 1.0, 2.0} is passed unchanged, with no swap on any step.
- Back-pressure: hold `down_ready`=0 for 10 cycles after `down_valid`. Required: `sorted`/`err` stable, `up_ready`=0 throughout, and `up_valid` pulses ignored (the second triple is not captured). Then `down_ready`=1 for one cycle gives a single transfer.
- NaN abort: {0x7FF8000000000000, 1.0, 2.0}. Required: `down_valid` 1 cycle after accept, `err`=1. A following clean job {2.0, 1.0, 3.0} then returns {1.0, 2.0, 3.0} with `err`=0 (sticky flag cleared).
- Reset mid-operation: assert `rst` for one cycle while in C12. Required: next cycle `up_ready`=1, `down_valid`=0, `sorted`=0, and no result is ever emitted for the dropped job.
- Back-to-back jobs with `up_valid` and `down_ready` held high and 20 random non-NaN triples. Required: results match a reference sort in order, with exactly one accept per 5 cycles.

Source files
------------

// File: rtl/sort_three_floats_seq.sv
// Three-entry floating-point sorter built around one shared comparator.
// A small FSM applies compare-and-swap to (r0,r1), (r1,r2), (r0,r1) on
// successive cycles. A NaN operand aborts the job and raises err.

// Ordered IEEE-754 "a <= b" test; err flags a NaN on either side.
module f_less_or_equal #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);

  localparam int EXP_W = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
  localparam int MAN_W = FLEN - 1 - EXP_W;

  logic            sign_a, sign_b;
  logic [FLEN-2:0] mag_a, mag_b;
  logic            nan_a, nan_b;

  assign sign_a = a[FLEN-1];
  assign sign_b = b[FLEN-1];
  assign mag_a  = a[FLEN-2:0];
  assign mag_b  = b[FLEN-2:0];
  assign nan_a  = (&a[FLEN-2:MAN_W]) && (|a[MAN_W-1:0]);
  assign nan_b  = (&b[FLEN-2:MAN_W]) && (|b[MAN_W-1:0]);

  // Sign-magnitude ordering; +0 and -0 compare equal.
  always_comb begin
    err = nan_a | nan_b;
    res = 1'b0;
    if (err) begin
      res = 1'b0;
    end else if ((mag_a == '0) && (mag_b == '0)) begin
      res = 1'b1;
    end else if (sign_a != sign_b) begin
      res = sign_a;
    end else if (!sign_a) begin
      res = (mag_a <= mag_b);
    end else begin
      res = (mag_a >= mag_b);
    end
  end

endmodule

module sort_three_floats_seq #(
  parameter int FLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [0:2][FLEN-1:0] unsorted,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [0:2][FLEN-1:0] sorted,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C01  = 3'd1,
    C12  = 3'd2,
    C01B = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [0:2][FLEN-1:0]  r_q, r_d;
  logic                  err_q, err_d;

  logic [FLEN-1:0]       cmp_a, cmp_b;
  logic                  cmp_res, cmp_err;

  // Only the middle step looks at (r1,r2); every other state presents (r0,r1).
  always_comb begin
    cmp_a = r_q[0];
    cmp_b = r_q[1];
    if (state_q == C12) begin
      cmp_a = r_q[1];
      cmp_b = r_q[2];
    end
  end

  f_less_or_equal #(.FLEN(FLEN)) u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  // State register plus data/error registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  // Next-state: fixed three-step schedule, early exit on comparator error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (up_valid) state_d = C01;
      C01:     state_d = cmp_err ? DONE : C12;
      C12:     state_d = cmp_err ? DONE : C01B;
      C01B:    state_d = DONE;
      DONE:    if (down_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, conditional swap of the compared pair.
  always_comb begin
    r_d   = r_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (up_valid) begin
          r_d   = unsorted;
          err_d = 1'b0;
        end
      end
      C01, C01B: begin
        if (cmp_err) begin
          err_d = 1'b1;
        end else if (!cmp_res) begin
          r_d[0] = r_q[1];
          r_d[1] = r_q[0];
        end
      end
      C12: begin
        if (cmp_err) begin
          err_d = 1'b1;
        end else if (!cmp_res) begin
          r_d[1] = r_q[2];
          r_d[2] = r_q[1];
        end
      end
      default: begin
        r_d   = r_q;
        err_d = err_q;
      end
    endcase
  end

  // Handshake outputs decode state only, so no combinational path from inputs.
  always_comb begin
    up_ready   = (state_q == IDLE);
    down_valid = (state_q == DONE);
  end

  assign sorted = r_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sort_three_floats_seq.sv
// Bench for sort_three_floats_seq: directed jobs plus a back-to-back random
// run, with a scoreboard filled at accept and drained at each transfer.
module tb_sort_three_floats_seq;

  localparam int FLEN = 64;
  localparam logic [63:0] D_M1  = 64'hBFF0000000000000;
  localparam logic [63:0] D_1   = 64'h3FF0000000000000;
  localparam logic [63:0] D_2   = 64'h4000000000000000;
  localparam logic [63:0] D_3   = 64'h4008000000000000;
  localparam logic [63:0] D_9   = 64'h4022000000000000;
  localparam logic [63:0] D_NAN = 64'h7FF8000000000000;

  logic                 clk;
  logic                 rst;
  logic                 up_valid;
  logic                 up_ready;
  logic [0:2][FLEN-1:0] unsorted;
  logic                 down_valid;
  logic                 down_ready;
  logic [0:2][FLEN-1:0] sorted;
  logic                 err;

  sort_three_floats_seq #(.FLEN(FLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .unsorted   (unsorted),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .sorted     (sorted),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] v0, v1, v2;
    logic        err;
    int          lat;
    int          acc;
  } job_t;

  job_t sb[$];

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Reference: three compare-exchange passes using real-number ordering.
  function automatic job_t model(input logic [63:0] a, b, c, input int acc);
    job_t        j;
    logic [63:0] r [3];
    logic [63:0] t;
    bit          stop;
    int          p;
    r[0] = a; r[1] = b; r[2] = c;
    j.err = 1'b0;
    j.lat = 3;
    j.acc = acc;
    stop  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!stop) begin
        p = (k == 1) ? 1 : 0;
        if (is_nan(r[p]) || is_nan(r[p+1])) begin
          j.err = 1'b1;
          j.lat = k + 1;
          stop  = 1'b1;
        end else if ($bitstoreal(r[p]) > $bitstoreal(r[p+1])) begin
          t = r[p]; r[p] = r[p+1]; r[p+1] = t;
        end
      end
    end
    j.v0 = r[0]; j.v1 = r[1]; j.v2 = r[2];
    return j;
  endfunction

  bit dv_prev  = 1'b0;
  bit b2b      = 1'b0;
  int last_acc = -1;

  // Monitor on the falling edge: push at accept, check latency, pop at transfer.
  always @(negedge clk) begin
    job_t h;
    if (rst) begin
      sb.delete();
      dv_prev = 1'b0;
    end else begin
      if (up_valid && up_ready) begin
        sb.push_back(model(unsorted[0], unsorted[1], unsorted[2], cyc + 1));
        if (b2b && last_acc >= 0) chk("accept_gap", 64'(cyc + 1 - last_acc), 64'd5);
        last_acc = cyc + 1;
      end
      if (down_valid && !dv_prev) begin
        if (sb.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (down_valid && down_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_transfer", 64'd1, 64'd0);
        end else begin
          h = sb.pop_front();
          chk("err", 64'(err), 64'(h.err));
          if (!h.err) begin
            chk("sorted0", sorted[0], h.v0);
            chk("sorted1", sorted[1], h.v1);
            chk("sorted2", sorted[2], h.v2);
          end
        end
      end
      dv_prev = down_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one job from IDLE with down_ready high; optionally verify no swaps.
  task automatic run_job(input logic [63:0] a, b, c, input bit nochange);
    int n;
    unsorted[0] = a; unsorted[1] = b; unsorted[2] = c;
    up_valid = 1'b1;
    down_ready = 1'b1;
    step();
    up_valid = 1'b0;
    n = 0;
    while (!down_valid && n < 10) begin
      if (nochange) begin
        chk("hold0", sorted[0], a);
        chk("hold1", sorted[1], b);
        chk("hold2", sorted[2], c);
      end
      step();
      n++;
    end
    if (!down_valid) chk("done_timeout", 64'd0, 64'd1);
    step();
    chk("up_ready_after_drain", 64'(up_ready), 64'd1);
    chk("dv_after_drain", 64'(down_valid), 64'd0);
  endtask

  function automatic logic [63:0] rnd_val();
    return $realtobits((real'($urandom_range(0, 80)) - 40.0) / 4.0);
  endfunction

  initial begin
    logic [0:2][FLEN-1:0] held;
    logic                 held_err;
    int                   n;
    rst = 1'b1;
    up_valid = 1'b0;
    down_ready = 1'b0;
    unsorted = '0;
    step();
    step();
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_down_valid", 64'(down_valid), 64'd0);
    chk("rst_sorted0", sorted[0], 64'd0);
    chk("rst_sorted2", sorted[2], 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    step();

    // Basic, reversed, ties, already sorted
    run_job(D_3, D_1, D_2, 1'b0);
    run_job(D_3, D_2, D_1, 1'b0);
    run_job(D_2, D_M1, D_2, 1'b0);
    run_job(D_M1, D_1, D_2, 1'b1);

    // Back-pressure with ignored up_valid pulses
    unsorted[0] = D_2; unsorted[1] = D_1; unsorted[2] = D_3;
    up_valid = 1'b1;
    down_ready = 1'b0;
    step();
    up_valid = 1'b0;
    n = 0;
    while (!down_valid && n < 10) begin step(); n++; end
    chk("bp_valid", 64'(down_valid), 64'd1);
    held = sorted;
    held_err = err;
    unsorted[0] = D_9; unsorted[1] = D_9; unsorted[2] = D_9;
    for (int i = 0; i < 10; i++) begin
      up_valid = i[0];
      step();
      chk("bp_up_ready", 64'(up_ready), 64'd0);
      chk("bp_down_valid", 64'(down_valid), 64'd1);
      chk("bp_s0", sorted[0], held[0]);
      chk("bp_s1", sorted[1], held[1]);
      chk("bp_s2", sorted[2], held[2]);
      chk("bp_err", 64'(held_err), 64'(err));
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    step();
    down_ready = 1'b0;
    chk("bp_drained", 64'(down_valid), 64'd0);
    step();
    chk("bp_single", 64'(down_valid), 64'd0);
    chk("bp_not_captured", sorted[0], D_1);

    // NaN aborts, then a clean job clears the sticky flag
    run_job(D_NAN, D_1, D_2, 1'b0);
    run_job(D_2, D_1, D_NAN, 1'b0);
    run_job(D_2, D_1, D_3, 1'b0);

    // Reset while in C12
    unsorted[0] = D_3; unsorted[1] = D_1; unsorted[2] = D_2;
    up_valid = 1'b1;
    down_ready = 1'b1;
    step();
    up_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_up_ready", 64'(up_ready), 64'd1);
    chk("mid_rst_down_valid", 64'(down_valid), 64'd0);
    chk("mid_rst_sorted0", sorted[0], 64'd0);
    chk("mid_rst_sorted1", sorted[1], 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("dropped_no_valid", 64'(down_valid), 64'd0);
    end

    // Back-to-back random jobs
    b2b = 1'b1;
    last_acc = -1;
    down_ready = 1'b1;
    up_valid = 1'b1;
    for (int j = 0; j < 20; j++) begin
      unsorted[0] = rnd_val(); unsorted[1] = rnd_val(); unsorted[2] = rnd_val();
      n = 0;
      while (!up_ready && n < 20) begin step(); n++; end
      if (!up_ready) chk("b2b_ready_timeout", 64'd0, 64'd1);
      step();
    end
    up_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin step(); n++; end
    chk("sb_empty", 64'(sb.size()), 64'd0);
    b2b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
